// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm pattern controller.
// The SNOOZE state only carries logic when ALARM_SNOOZE_EN is defined.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } alarm_state_t;

   localparam logic ALARM_ON_CODE = 1'b1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/alarm_down_counter.sv
// Loadable down counter that stops at zero and flags it; used for the ring/snooze
// duration and the blink half-period.
module alarm_down_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && (count != '0))
         count <= count - W'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/alarm_pattern_ctrl.sv
// Multi-channel alarm ringer: latches requests, serves the lowest pending channel,
// drives a steady or blinking indicator. Snooze support under `ALARM_SNOOZE_EN.
module alarm_pattern_ctrl
   import alarm_pkg::*;
#(
   parameter int N_CH        = 2,
   parameter int SEG_W       = 7,
   parameter int ALARM_TIME  = 10_000_000,
   parameter int BLINK_HALF  = 1_000_000,
   parameter int SNOOZE_TIME = 50_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  alarm_trigger,
   input  logic             alarm_ack,
   input  logic             snooze,
   input  logic             blink_en,
   output logic [0:SEG_W-1] alarm_signal,
   output logic [N_CH-1:0]  active_ch,
   output logic             busy
);

   localparam int                CNT_W      = $clog2(max3(ALARM_TIME, SNOOZE_TIME, BLINK_HALF)) + 1;
   localparam logic [CNT_W-1:0]  RING_LOAD  = CNT_W'(ALARM_TIME - 1);
   localparam logic [CNT_W-1:0]  BLINK_LOAD = CNT_W'(BLINK_HALF - 1);
   localparam logic [0:SEG_W-1]  ON_PATTERN = {SEG_W{ALARM_ON_CODE}};
`ifdef ALARM_SNOOZE_EN
   localparam logic [CNT_W-1:0]  SNOOZE_LOAD = CNT_W'(SNOOZE_TIME - 1);
`else
   logic unused_snooze;
   assign unused_snooze = snooze;
`endif

   alarm_state_t     state, state_n;
   logic [N_CH-1:0]  pending, clr, act_n;
   logic             phase, phase_n;
   logic [0:SEG_W-1] sig_n;
   logic             dur_load, dur_en, dur_zero;
   logic [CNT_W-1:0] dur_val;
   logic             blk_load, blk_en, blk_zero;

   alarm_down_counter #(.W(CNT_W)) u_dur (
      .clk(clk), .rst(rst), .load(dur_load), .load_val(dur_val), .en(dur_en), .zero(dur_zero)
   );

   alarm_down_counter #(.W(CNT_W)) u_blink (
      .clk(clk), .rst(rst), .load(blk_load), .load_val(BLINK_LOAD), .en(blk_en), .zero(blk_zero)
   );

   // Event priority while serving a channel: ack, then snooze, then retrigger, then expiry.
   always_comb begin
      state_n  = state;
      act_n    = active_ch;
      phase_n  = phase;
      clr      = '0;
      dur_load = 1'b0;
      dur_val  = RING_LOAD;
      dur_en   = 1'b0;
      blk_load = 1'b0;
      blk_en   = 1'b0;
      case (state)
         IDLE: begin
            if (pending != '0) begin
               state_n  = RING;
               act_n    = pending & (~pending + N_CH'(1));
               dur_load = 1'b1;
               blk_load = 1'b1;
               phase_n  = 1'b1;
            end
         end
         RING: begin
            if (alarm_ack) begin
               state_n = IDLE;
               clr     = active_ch;
               act_n   = '0;
            end
`ifdef ALARM_SNOOZE_EN
            else if (snooze) begin
               state_n  = SNOOZE;
               dur_load = 1'b1;
               dur_val  = SNOOZE_LOAD;
            end
`endif
            else begin
               if ((alarm_trigger & active_ch) != '0)
                  dur_load = 1'b1;
               else if (dur_zero) begin
                  state_n = IDLE;
                  clr     = active_ch;
                  act_n   = '0;
               end else
                  dur_en = 1'b1;
               if ((state_n == RING) && blink_en) begin
                  if (blk_zero) begin
                     phase_n  = ~phase;
                     blk_load = 1'b1;
                  end else
                     blk_en = 1'b1;
               end
            end
         end
`ifdef ALARM_SNOOZE_EN
         SNOOZE: begin
            if (alarm_ack) begin
               state_n = IDLE;
               clr     = active_ch;
               act_n   = '0;
            end else if (dur_zero) begin
               state_n  = RING;
               dur_load = 1'b1;
               blk_load = 1'b1;
               phase_n  = 1'b1;
            end else
               dur_en = 1'b1;
         end
`endif
         default: begin
            state_n = IDLE;
            act_n   = '0;
         end
      endcase
      sig_n = ((state_n == RING) && (!blink_en || phase_n)) ? ON_PATTERN : '0;
   end

   // A clear for the served channel beats a same-cycle request on that channel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         pending      <= '0;
         active_ch    <= '0;
         phase        <= 1'b0;
         alarm_signal <= '0;
         busy         <= 1'b0;
      end else begin
         state        <= state_n;
         pending      <= (pending | alarm_trigger) & ~clr;
         active_ch    <= act_n;
         phase        <= phase_n;
         alarm_signal <= sig_n;
         busy         <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_alarm_pattern_ctrl.sv
// Self-checking bench for alarm_pattern_ctrl: directed scenarios plus random traffic
// against a cycle-count reference model. Snooze checks follow ALARM_SNOOZE_EN.
module tb_alarm_pattern_ctrl;

   localparam int AT = 8;
   localparam int BH = 2;
   localparam int ST = 5;
`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ_EN = 1'b1;
`else
   localparam bit SNZ_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] alarm_trigger = '0;
   logic       alarm_ack = 1'b0;
   logic       snooze = 1'b0;
   logic       blink_en = 1'b0;
   logic [0:6] alarm_signal;
   logic [1:0] active_ch;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: served channel, cycles left, blink steps since ring start
   int       m_ch = -1;
   bit       m_snz = 1'b0;
   int       m_left = 0;
   int       m_bk = 0;
   bit       m_ben = 1'b0;
   bit [1:0] m_pend = '0;

   alarm_pattern_ctrl #(
      .N_CH(2), .SEG_W(7), .ALARM_TIME(AT), .BLINK_HALF(BH), .SNOOZE_TIME(ST)
   ) dut (
      .clk(clk), .rst(rst), .alarm_trigger(alarm_trigger), .alarm_ack(alarm_ack),
      .snooze(snooze), .blink_en(blink_en), .alarm_signal(alarm_signal),
      .active_ch(active_ch), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      if (observed !== expected) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      m_ch = -1; m_snz = 1'b0; m_left = 0; m_bk = 0; m_pend = '0;
   endtask

   task automatic modelStep(input logic [1:0] trig, input logic ack, input logic snz, input logic ben);
      bit [1:0] clr;
      clr   = '0;
      m_ben = ben;
      if (m_ch < 0) begin
         for (int i = 1; i >= 0; i--)
            if (m_pend[i]) m_ch = i;
         if (m_ch >= 0) begin
            m_snz = 1'b0; m_left = AT; m_bk = 0;
         end
      end else if (ack) begin
         clr[m_ch] = 1'b1; m_ch = -1; m_snz = 1'b0;
      end else if (SNZ_EN && snz && !m_snz) begin
         m_snz = 1'b1; m_left = ST;
      end else if (m_snz) begin
         if (m_left == 1) begin
            m_snz = 1'b0; m_left = AT; m_bk = 0;
         end else
            m_left--;
      end else begin
         if (trig[m_ch])
            m_left = AT;
         else if (m_left == 1) begin
            clr[m_ch] = 1'b1; m_ch = -1;
         end else
            m_left--;
         if (m_ch >= 0 && ben) m_bk++;
      end
      m_pend = (m_pend | trig) & ~clr;
   endtask

   task automatic applyStimulus(input logic [1:0] trig, input logic ack, input logic snz,
                                input logic ben, input string tag);
      logic [6:0] exp_sig;
      logic [1:0] exp_act;
      alarm_trigger = trig; alarm_ack = ack; snooze = snz; blink_en = ben;
      @(posedge clk);
      modelStep(trig, ack, snz, ben);
      #1;
      exp_act = (m_ch >= 0) ? 2'(1 << m_ch) : 2'b00;
      exp_sig = (m_ch >= 0 && !m_snz && (!m_ben || ((m_bk / BH) % 2 == 0))) ? 7'h7F : 7'h00;
      checkOutput({tag, "_sig"}, 32'(alarm_signal), 32'(exp_sig));
      checkOutput({tag, "_act"}, 32'(active_ch), 32'(exp_act));
      checkOutput({tag, "_busy"}, 32'(busy), 32'(m_ch >= 0));
   endtask

   task automatic resetDut(input string tag);
      alarm_trigger = '0; alarm_ack = 1'b0; snooze = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput({tag, "_rst_sig"}, 32'(alarm_signal), 32'h0);
      checkOutput({tag, "_rst_act"}, 32'(active_ch), 32'h0);
      checkOutput({tag, "_rst_busy"}, 32'(busy), 32'h0);
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      int on_cnt, off_cnt, c0, c1, gap, nb;
      logic [7:0] pat;
      logic [1:0] trig;

      #3;
      resetDut("init");

      // Single steady ring on channel 0
      on_cnt = 0;
      applyStimulus(2'b01, 0, 0, 0, "t1");
      for (int k = 0; k < 12; k++) begin
         applyStimulus(2'b00, 0, 0, 0, "t1");
         if (alarm_signal == 7'h7F && active_ch == 2'b01) on_cnt++;
      end
      checkOutput("t1_on_cycles", on_cnt, AT);
      checkOutput("t1_end_busy", 32'(busy), 32'h0);

      // Blinking ring
      resetDut("t2");
      pat = '0; nb = 0;
      applyStimulus(2'b01, 0, 0, 1, "t2");
      for (int k = 0; k < 12; k++) begin
         applyStimulus(2'b00, 0, 0, 1, "t2");
         if (busy && nb < 8) begin
            pat = {pat[6:0], alarm_signal == 7'h7F};
            nb++;
         end
      end
      checkOutput("t2_pattern", 32'(pat), 32'hCC);

      // Two channels requested together
      resetDut("t3");
      c0 = 0; c1 = 0; gap = 0;
      applyStimulus(2'b11, 0, 0, 0, "t3");
      for (int k = 0; k < 22; k++) begin
         applyStimulus(2'b00, 0, 0, 0, "t3");
         if (active_ch == 2'b01) c0++;
         if (active_ch == 2'b10) c1++;
         if (c0 == AT && c1 == 0 && active_ch == 2'b00 && !busy) gap++;
      end
      checkOutput("t3_ch0_cycles", c0, AT);
      checkOutput("t3_ch1_cycles", c1, AT);
      checkOutput("t3_idle_gap", gap, 1);

`ifdef ALARM_SNOOZE_EN
      // Snooze at ring cycle 3, full ring after, then ack a later ring
      resetDut("t4");
      on_cnt = 0; off_cnt = 0;
      applyStimulus(2'b01, 0, 0, 0, "t4");
      repeat (3) applyStimulus(2'b00, 0, 0, 0, "t4");
      applyStimulus(2'b00, 0, 1, 0, "t4");
      for (int k = 0; k < 16; k++) begin
         if (busy && alarm_signal == 7'h00) off_cnt++;
         applyStimulus(2'b00, 0, 0, 0, "t4");
         if (alarm_signal == 7'h7F) on_cnt++;
      end
      checkOutput("t4_snooze_off", off_cnt, ST);
      checkOutput("t4_ring_after", on_cnt, AT);
      applyStimulus(2'b01, 0, 0, 0, "t4b");
      repeat (3) applyStimulus(2'b00, 0, 0, 0, "t4b");
      applyStimulus(2'b00, 1, 0, 0, "t4b");
      checkOutput("t4_ack_idle", 32'(busy), 32'h0);
      checkOutput("t4_ack_sig", 32'(alarm_signal), 32'h0);
`endif

      // Ack beats snooze; retrigger extends the ring
      resetDut("t5");
      applyStimulus(2'b01, 0, 0, 0, "t5");
      repeat (2) applyStimulus(2'b00, 0, 0, 0, "t5");
      applyStimulus(2'b00, 1, 1, 0, "t5");
      checkOutput("t5_ack_wins_busy", 32'(busy), 32'h0);
      checkOutput("t5_ack_wins_act", 32'(active_ch), 32'h0);
      repeat (2) applyStimulus(2'b00, 0, 0, 0, "t5");
      on_cnt = 0;
      applyStimulus(2'b01, 0, 0, 0, "t5r");
      for (int k = 0; k < 6; k++) begin
         applyStimulus(2'b00, 0, 0, 0, "t5r");
         if (alarm_signal == 7'h7F) on_cnt++;
      end
      applyStimulus(2'b01, 0, 0, 0, "t5r");
      if (alarm_signal == 7'h7F) on_cnt++;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(2'b00, 0, 0, 0, "t5r");
         if (alarm_signal == 7'h7F) on_cnt++;
      end
      checkOutput("t5_extended_ring", on_cnt, 6 + AT);

      // Reset mid-ring with channel 1 still pending
      resetDut("t6a");
      applyStimulus(2'b11, 0, 0, 0, "t6");
      repeat (3) applyStimulus(2'b00, 0, 0, 0, "t6");
      checkOutput("t6_ringing_ch0", 32'(active_ch), 32'h1);
      resetDut("t6");
      nb = 0;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(2'b00, 0, 0, 0, "t6post");
         if (busy) nb++;
      end
      checkOutput("t6_no_ring_after_reset", nb, 0);

      // Random traffic against the model
      for (int b = 0; b < 4; b++) begin
         logic ben;
         resetDut("rnd");
         ben = 1'($urandom_range(0, 1));
         for (int k = 0; k < 200; k++) begin
            trig = {($urandom % 8) == 0, ($urandom % 8) == 0};
            applyStimulus(trig, ($urandom % 16) == 0, ($urandom % 10) == 0, ben, "rnd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
